// File: rtl/gray_decoder_rx_if.sv
// Handshake bundle between a Gray-coded count source and gray_decoder_rx.
// The master drives the Gray count and enable; the slave returns the decoded value and its status.
interface gray_decoder_rx_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] gray_in;
  logic             enable;
  logic [WIDTH-1:0] binary_out;
  logic             valid;
  logic             step_up;
  logic             step_down;
  logic             hold;
  logic             error;
  logic [7:0]       err_count;

  modport master (
    output gray_in, enable,
    input  binary_out, valid, step_up, step_down, hold, error, err_count
  );

  modport slave (
    input  gray_in, enable,
    output binary_out, valid, step_up, step_down, hold, error, err_count
  );
endinterface

// File: rtl/gray_decoder_rx.sv
// Receive side of a Gray-coded count: synchronizes it, converts it to binary, and
// classifies each step as hold, +1, -1 or illegal, with a relock window after a fault.
module gray_decoder_rx #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int RELOCK      = 4
) (
  input  logic              clk,
  input  logic              reset,
  gray_decoder_rx_if.slave  bus
);

  typedef enum logic [1:0] {ACQUIRE, TRACK, FAULT} state_t;

  localparam int                 CNT_W       = $clog2(RELOCK + 1);
  localparam logic [CNT_W-1:0]   RELOCK_LAST = CNT_W'(RELOCK - 1);

  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] decoded;
  logic [WIDTH-1:0] delta;
  logic             is_hold, is_up, is_down;

  state_t           state;
  logic [WIDTH-1:0] prev_r;
  logic [CNT_W-1:0] relock_cnt;

  // The sync chain runs regardless of enable so a stale sample never lingers.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      // NOTE: this flop array is reset element by element; a RAM-style array would not be.
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
    end else begin
      sync_r[0] <= bus.gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  assign sync_q = sync_r[SYNC_STAGES-1];

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    decoded            = '0;
    decoded[WIDTH-1]   = sync_q[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) decoded[i] = decoded[i+1] ^ sync_q[i];
  end

  // Modulo-2^WIDTH difference: 0 is hold, 1 is +1, all-ones is -1 (wrap included).
  assign delta   = decoded - prev_r;
  assign is_hold = (delta == '0);
  assign is_up   = (delta == WIDTH'(1));
  assign is_down = (delta == '1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ACQUIRE;
      prev_r         <= '0;
      relock_cnt     <= '0;
      bus.binary_out <= '0;
      bus.valid      <= 1'b0;
      bus.step_up    <= 1'b0;
      bus.step_down  <= 1'b0;
      bus.hold       <= 1'b0;
      bus.error      <= 1'b0;
      bus.err_count  <= '0;
    end else begin
      bus.step_up   <= 1'b0;
      bus.step_down <= 1'b0;
      bus.hold      <= 1'b0;
      bus.error     <= 1'b0;
      if (bus.enable) begin
        prev_r         <= decoded;
        bus.binary_out <= decoded;
        case (state)
          ACQUIRE: begin
            state     <= TRACK;
            bus.valid <= 1'b1;
          end
          TRACK: begin
            if (is_hold)      bus.hold      <= 1'b1;
            else if (is_up)   bus.step_up   <= 1'b1;
            else if (is_down) bus.step_down <= 1'b1;
            else begin
              bus.error  <= 1'b1;
              bus.valid  <= 1'b0;
              relock_cnt <= '0;
              state      <= FAULT;
              if (bus.err_count != 8'hFF) bus.err_count <= bus.err_count + 8'd1;
            end
          end
          FAULT: begin
            // Only an unbroken run of RELOCK identical samples restores tracking.
            if (is_hold) begin
              bus.hold <= 1'b1;
              if (relock_cnt == RELOCK_LAST) begin
                relock_cnt <= '0;
                bus.valid  <= 1'b1;
                state      <= TRACK;
              end else begin
                relock_cnt <= relock_cnt + 1'b1;
              end
            end else begin
              relock_cnt <= '0;
            end
          end
          default: state <= ACQUIRE;
        endcase
      end
    end
  end

endmodule
